srio_nwr_arbiter: RTL and testbench

// Round-robin arbiter/sequencer sharing the single SRIO NWRITE user stream among NUM_REQ packet sources.

---
 rtl/srio_nwr_arbiter_pkg.sv | 31 +++
 rtl/srio_nwr_arbiter_if.sv | 62 ++++++
 rtl/srio_nwr_arbiter_rr_pick.sv | 50 +++++
 rtl/srio_nwr_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_srio_nwr_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/srio_nwr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// srio_nwr_pkg
// Shared types and widths for the SRIO NWRITE round-robin arbiter.
//   state_e        : arbiter FSM states (IDLE, XFER, WAIT_DONE)
//   ADDR_W/TSIZE_W : widths of the per-packet target address and size (bytes-1)
//   DATA_W/KEEP_W  : width of one user-stream data beat and its byte enables
//   BEAT_W         : width able to hold the expected beat count of any packet
//   expected_beats : number of 8-byte beats implied by a size field
// -----------------------------------------------------------------------------
package srio_nwr_pkg;

  localparam int ADDR_W  = 34;
  localparam int TSIZE_W = 20;
  localparam int DATA_W  = 64;
  localparam int KEEP_W  = 8;

  // tsize[19:3] + 1 can reach 2^17, so one extra bit keeps it from wrapping.
  localparam int BEAT_W  = TSIZE_W - 3 + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    XFER      = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  // Beats of 8 bytes needed to carry (tsize + 1) bytes.
  function automatic logic [BEAT_W-1:0] expected_beats(input logic [TSIZE_W-1:0] tsize);
    return {1'b0, tsize[TSIZE_W-1:3]} + BEAT_W'(1);
  endfunction

endpackage

// File: rtl/srio_nwr_arbiter_if.sv
// -----------------------------------------------------------------------------
// srio_nwr_arbiter_if
// Bundle of every handshake/bus signal around the NWRITE arbiter.
//   req_*        : NUM_REQ packed per-source request, header and beat signals
//   grant_o      : one-hot grant back to the sources
//   nwr_*        : NWRITE engine status (ready / busy / done pulse)
//   user_*       : muxed packet header and beat stream toward the engine
//   len_err_o    : beat-count mismatch pulse
//   timeout_o    : done-not-seen pulse
// Modports:
//   master : the arbiter side (drives grant, ready-back and the user stream)
//   slave  : the environment side (sources plus engine)
// -----------------------------------------------------------------------------
interface srio_nwr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import srio_nwr_pkg::*;

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*TSIZE_W-1:0] req_tsize_i;
  logic [NUM_REQ*DATA_W-1:0] req_tdata_i;
  logic [NUM_REQ*KEEP_W-1:0] req_tkeep_i;
  logic [NUM_REQ-1:0]        req_tvalid_i;
  logic [NUM_REQ-1:0]        req_tlast_i;
  logic [NUM_REQ-1:0]        req_tready_o;
  logic [NUM_REQ-1:0]        grant_o;

  logic                      nwr_ready_in;
  logic                      nwr_busy_in;
  logic                      nwr_done_in;
  logic                      user_tready_in;

  logic [ADDR_W-1:0]         user_addr_o;
  logic [TSIZE_W-1:0]        user_tsize_o;
  logic [DATA_W-1:0]         user_tdata_o;
  logic [KEEP_W-1:0]         user_tkeep_o;
  logic                      user_tvalid_o;
  logic                      user_tlast_o;
  logic                      user_tfirst_o;
  logic                      len_err_o;
  logic                      timeout_o;

  modport master (
    input  req_valid_i, req_addr_i, req_tsize_i, req_tdata_i, req_tkeep_i,
    input  req_tvalid_i, req_tlast_i,
    input  nwr_ready_in, nwr_busy_in, nwr_done_in, user_tready_in,
    output req_tready_o, grant_o,
    output user_addr_o, user_tsize_o, user_tdata_o, user_tkeep_o,
    output user_tvalid_o, user_tlast_o, user_tfirst_o, len_err_o, timeout_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_tsize_i, req_tdata_i, req_tkeep_i,
    output req_tvalid_i, req_tlast_i,
    output nwr_ready_in, nwr_busy_in, nwr_done_in, user_tready_in,
    input  req_tready_o, grant_o,
    input  user_addr_o, user_tsize_o, user_tdata_o, user_tkeep_o,
    input  user_tvalid_o, user_tlast_o, user_tfirst_o, len_err_o, timeout_o
  );

endinterface

// File: rtl/srio_nwr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// srio_rr_pick
// Combinational round-robin picker. Searches req_i starting at last_i+1 and
// wrapping, and returns the first requester found.
//   req_i       in  NUM_REQ  request vector
//   last_i      in  IDX_W    index granted most recently
//   grant_oh_o  out NUM_REQ  one-hot winner (all zero when nothing requests)
//   grant_idx_o out IDX_W    winner index (0 when nothing requests)
//   any_o       out 1        at least one requester present
// -----------------------------------------------------------------------------
module srio_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o
);

  // cand_idx[n] is the source examined at search position n, i.e.
  // (last_i + 1 + n) mod NUM_REQ. One extra bit holds the unwrapped sum.
  logic [IDX_W-1:0] cand_idx [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum = {1'b0, last_i} + (IDX_W+1)'(gi + 1);
    assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                        ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                        : sum[IDX_W-1:0];
  end

  logic found;

  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[cand_idx[i]]) begin
        found                   = 1'b1;
        grant_oh_o[cand_idx[i]] = 1'b1;
        grant_idx_o             = cand_idx[i];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/srio_nwr_arbiter.sv
// -----------------------------------------------------------------------------
// srio_nwr_arbiter
// Shares the single SRIO NWRITE user stream among NUM_REQ packet sources.
// One source is granted per packet; its header is latched and its beats are
// muxed onto the engine port until the engine reports the packet done.
//   log_clk   in  clock, all logic on the rising edge
//   log_rst   in  synchronous active-high reset
//   bus       master modport of srio_nwr_arbiter_if (sources, engine status,
//             muxed user stream, grant, len_err_o and timeout_o pulses)
// Parameters:
//   NUM_REQ       number of sources (2..8)
//   DONE_TIMEOUT  cycles to wait for nwr_done_in after tlast (>=2)
// -----------------------------------------------------------------------------
module srio_nwr_arbiter
  import srio_nwr_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic               log_clk,
  input  logic               log_rst,
  srio_nwr_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TO_W  = $clog2(DONE_TIMEOUT + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q,     state_d;
  logic [NUM_REQ-1:0]   grant_q,     grant_d;
  logic [IDX_W-1:0]     gidx_q,      gidx_d;
  logic [IDX_W-1:0]     last_q,      last_d;
  logic [ADDR_W-1:0]    addr_q,      addr_d;
  logic [TSIZE_W-1:0]   tsize_q,     tsize_d;
  logic [BEAT_W-1:0]    beat_cnt_q,  beat_cnt_d;
  logic                 done_seen_q, done_seen_d;
  logic [TO_W-1:0]      to_cnt_q,    to_cnt_d;
  logic                 len_err_q,   len_err_d;
  logic                 timeout_q,   timeout_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick among pending requests
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  srio_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i       (bus.req_valid_i),
    .last_i      (last_q),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx),
    .any_o       (pick_any)
  );

  // ---------------------------------------------------------------------------
  // Beat mux: the granted source drives the user stream only while in XFER
  // ---------------------------------------------------------------------------
  logic                sel_tvalid;
  logic                sel_tlast;
  logic [DATA_W-1:0]   sel_tdata;
  logic [KEEP_W-1:0]   sel_tkeep;

  assign sel_tvalid = bus.req_tvalid_i[gidx_q];
  assign sel_tlast  = bus.req_tlast_i[gidx_q];
  assign sel_tdata  = bus.req_tdata_i[int'(gidx_q)*DATA_W +: DATA_W];
  assign sel_tkeep  = bus.req_tkeep_i[int'(gidx_q)*KEEP_W +: KEEP_W];

  logic                user_tvalid;
  logic                user_tlast;
  logic [DATA_W-1:0]   user_tdata;
  logic [KEEP_W-1:0]   user_tkeep;
  logic [NUM_REQ-1:0]  req_tready;

  always_comb begin
    user_tvalid = 1'b0;
    user_tlast  = 1'b0;
    user_tdata  = '0;
    user_tkeep  = '0;
    req_tready  = '0;
    if (state_q == XFER) begin
      user_tvalid        = sel_tvalid;
      user_tlast         = sel_tlast;
      user_tdata         = sel_tdata;
      user_tkeep         = sel_tkeep;
      req_tready[gidx_q] = bus.user_tready_in;
    end
  end

  logic              beat_acc;
  logic [BEAT_W-1:0] beat_cnt_inc;
  logic [TO_W-1:0]   to_cnt_inc;
  logic              engine_free;

  assign beat_acc     = user_tvalid && bus.user_tready_in;
  assign beat_cnt_inc = beat_cnt_q + BEAT_W'(1);
  assign to_cnt_inc   = to_cnt_q + TO_W'(1);
  assign engine_free  = bus.nwr_ready_in && !bus.nwr_busy_in;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    last_d      = last_q;
    addr_d      = addr_q;
    tsize_d     = tsize_q;
    beat_cnt_d  = beat_cnt_q;
    done_seen_d = done_seen_q;
    to_cnt_d    = to_cnt_q;
    len_err_d   = 1'b0;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any && engine_free) begin
          state_d     = XFER;
          grant_d     = pick_oh;
          gidx_d      = pick_idx;
          addr_d      = bus.req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
          tsize_d     = bus.req_tsize_i[int'(pick_idx)*TSIZE_W +: TSIZE_W];
          beat_cnt_d  = '0;
          done_seen_d = 1'b0;
        end
      end

      XFER: begin
        // The engine may finish before the last beat is handed over; remember it.
        if (bus.nwr_done_in) begin
          done_seen_d = 1'b1;
        end
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_inc;
          if (user_tlast) begin
            len_err_d = (beat_cnt_inc != expected_beats(tsize_q));
            to_cnt_d  = '0;
            if (done_seen_q || bus.nwr_done_in) begin
              state_d = IDLE;
              grant_d = '0;
              last_d  = gidx_q;
            end else begin
              state_d = WAIT_DONE;
            end
          end
        end
      end

      WAIT_DONE: begin
        to_cnt_d = to_cnt_inc;
        if (bus.nwr_done_in) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end else if (to_cnt_inc == TO_W'(DONE_TIMEOUT)) begin
          // Give up on this packet so the other sources are not starved.
          timeout_d = 1'b1;
          state_d   = IDLE;
          grant_d   = '0;
          last_d    = gidx_q;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      // Start as if the highest source was served last so source 0 wins first.
      last_q      <= IDX_W'(NUM_REQ - 1);
      addr_q      <= '0;
      tsize_q     <= '0;
      beat_cnt_q  <= '0;
      done_seen_q <= 1'b0;
      to_cnt_q    <= '0;
      len_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      tsize_q     <= tsize_d;
      beat_cnt_q  <= beat_cnt_d;
      done_seen_q <= done_seen_d;
      to_cnt_q    <= to_cnt_d;
      len_err_q   <= len_err_d;
      timeout_q   <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.grant_o       = grant_q;
  assign bus.req_tready_o  = req_tready;
  assign bus.user_addr_o   = addr_q;
  assign bus.user_tsize_o  = tsize_q;
  assign bus.user_tdata_o  = user_tdata;
  assign bus.user_tkeep_o  = user_tkeep;
  assign bus.user_tvalid_o = user_tvalid;
  assign bus.user_tlast_o  = user_tlast;
  assign bus.user_tfirst_o = user_tvalid && (beat_cnt_q == '0);
  assign bus.len_err_o     = len_err_q;
  assign bus.timeout_o     = timeout_q;

endmodule

// File: tb/tb_srio_nwr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_srio_nwr_arbiter
// Directed bench for srio_nwr_arbiter: a table of packet records drives the
// main flows, plus hand-written sequences for engine gating and mid-packet
// reset. Inputs change 1 time unit after the rising edge; outputs are read
// in the same window, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_srio_nwr_arbiter;
  import srio_nwr_pkg::*;

  localparam int NR = 4;
  localparam int DT = 16;

  logic log_clk = 1'b0;
  logic log_rst;

  always #5 log_clk = ~log_clk;

  srio_nwr_arbiter_if #(.NUM_REQ(NR)) bus ();

  srio_nwr_arbiter #(
    .NUM_REQ      (NR),
    .DONE_TIMEOUT (DT)
  ) dut (
    .log_clk (log_clk),
    .log_rst (log_rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // done_mode: >0 done pulse that many cycles after the tlast edge,
  //            0 done on the tlast cycle, 99 done during beat 0,
  //            -1 never (timeout expected).
  typedef struct {
    logic [NR-1:0] mask;
    int            src;
    logic [19:0]   tsize;
    int            nbeats;
    int            done_mode;
    int            stall_at;
    logic          exp_err;
  } pkt_vec_t;

  pkt_vec_t vecs [10];

  task automatic step();
    @(posedge log_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_data(input int src, input int b);
    return {8'hA5, 8'(src), 16'h0000, 32'(b)};
  endfunction

  function automatic logic [7:0] mk_keep(input int b);
    return 8'(b * 3 + 1);
  endfunction

  function automatic logic [33:0] mk_addr(input int k);
    return {2'b10, 16'h1234, 8'(k), 8'h40};
  endfunction

  task automatic run_pkt(input int id, input pkt_vec_t v);
    int waited;
    int acc;
    int n;
    logic [NR-1:0] exp_g;
    exp_g = NR'(1) << v.src;
    bus.req_valid_i = v.mask;
    for (int k = 0; k < NR; k++) begin
      if (v.mask[k]) bus.req_tsize_i[k*20 +: 20] = v.tsize;
    end
    waited = 0;
    do begin
      step();
      waited++;
    end while (bus.grant_o == '0 && waited < 20);
    check("grant_latency", 64'(waited), 64'd1);
    check("grant", 64'(bus.grant_o), 64'(exp_g));
    check("user_addr", 64'(bus.user_addr_o), 64'(mk_addr(v.src)));
    check("user_tsize", 64'(bus.user_tsize_o), 64'(v.tsize));
    if ($countones(v.mask) == 1) bus.req_valid_i = '0;

    acc = 0;
    for (int b = 0; b < v.nbeats; b++) begin
      bus.req_tvalid_i[v.src]           = 1'b1;
      bus.req_tdata_i[v.src*64 +: 64]   = mk_data(v.src, b);
      bus.req_tkeep_i[v.src*8 +: 8]     = mk_keep(b);
      bus.req_tlast_i[v.src]            = (b == v.nbeats - 1);
      bus.nwr_done_in = (v.done_mode == 99 && b == 0) ||
                        (v.done_mode == 0 && b == v.nbeats - 1);
      if (b == v.stall_at) begin
        bus.user_tready_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          check("stall_tvalid", 64'(bus.user_tvalid_o), 64'd1);
          check("stall_tready", 64'(bus.req_tready_o), 64'd0);
          check("stall_tdata", bus.user_tdata_o, mk_data(v.src, b));
          step();
        end
        bus.user_tready_in = 1'b1;
      end
      #1;
      check("tdata", bus.user_tdata_o, mk_data(v.src, b));
      check("tkeep", 64'(bus.user_tkeep_o), 64'(mk_keep(b)));
      check("req_tready", 64'(bus.req_tready_o), 64'(exp_g));
      check("tfirst", 64'(bus.user_tfirst_o), 64'(b == 0));
      check("tlast", 64'(bus.user_tlast_o), 64'(b == v.nbeats - 1));
      if (bus.req_tready_o[v.src] && bus.user_tvalid_o) acc++;
      step();
      bus.nwr_done_in = 1'b0;
    end
    check("beats", 64'(acc), 64'(v.nbeats));

    // Source keeps tvalid high after tlast: nothing may pass once XFER ends.
    bus.req_tlast_i[v.src] = 1'b0;
    bus.req_tdata_i[v.src*64 +: 64] = mk_data(v.src, v.nbeats);
    #1;
    check("len_err", 64'(bus.len_err_o), 64'(v.exp_err));
    check("post_tvalid", 64'(bus.user_tvalid_o), 64'd0);
    check("post_tready", 64'(bus.req_tready_o), 64'd0);
    bus.req_tvalid_i[v.src] = 1'b0;

    if (v.done_mode == 0 || v.done_mode == 99) begin
      check("grant_rel_direct", 64'(bus.grant_o), 64'd0);
    end else if (v.done_mode > 0) begin
      for (int d = 1; d < v.done_mode; d++) step();
      check("grant_hold", 64'(bus.grant_o), 64'(exp_g));
      bus.nwr_done_in = 1'b1;
      step();
      bus.nwr_done_in = 1'b0;
      check("grant_rel", 64'(bus.grant_o), 64'd0);
      check("len_err_once", 64'(bus.len_err_o), 64'd0);
    end else begin
      n = 0;
      while (!bus.timeout_o && n < 40) begin
        step();
        n++;
      end
      check("timeout_delay", 64'(n), 64'(DT));
      check("timeout_grant", 64'(bus.grant_o), 64'd0);
      step();
      check("timeout_pulse", 64'(bus.timeout_o), 64'd0);
    end
    $display("pkt %0d src %0d tsize %0d beats %0d done_mode %0d", id, v.src, v.tsize, v.nbeats, v.done_mode);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    pkt_vec_t rv;

    vecs[0] = '{4'b0001, 0, 20'd7,   1,  3, -1, 1'b0};
    vecs[1] = '{4'b1110, 1, 20'd15,  2,  1, -1, 1'b0};
    vecs[2] = '{4'b1110, 2, 20'd15,  2,  1, -1, 1'b0};
    vecs[3] = '{4'b1110, 3, 20'd15,  2,  1, -1, 1'b0};
    vecs[4] = '{4'b1110, 1, 20'd15,  2,  1, -1, 1'b0};
    vecs[5] = '{4'b0001, 0, 20'd255, 32, 2, 10, 1'b0};
    vecs[6] = '{4'b0100, 2, 20'd31,  3,  2, -1, 1'b1};
    vecs[7] = '{4'b1000, 3, 20'd7,   1, -1, -1, 1'b0};
    vecs[8] = '{4'b0001, 0, 20'd15,  2,  0, -1, 1'b0};
    vecs[9] = '{4'b0010, 1, 20'd23,  3, 99, -1, 1'b0};

    bus.req_valid_i    = '0;
    bus.req_tsize_i    = '0;
    bus.req_tdata_i    = '0;
    bus.req_tkeep_i    = '0;
    bus.req_tvalid_i   = '0;
    bus.req_tlast_i    = '0;
    bus.nwr_ready_in   = 1'b0;
    bus.nwr_busy_in    = 1'b0;
    bus.nwr_done_in    = 1'b0;
    bus.user_tready_in = 1'b0;
    for (int k = 0; k < NR; k++) bus.req_addr_i[k*34 +: 34] = mk_addr(k);
    log_rst = 1'b1;
    repeat (3) step();

    check("rst_grant", 64'(bus.grant_o), 64'd0);
    check("rst_tvalid", 64'(bus.user_tvalid_o), 64'd0);
    check("rst_addr", 64'(bus.user_addr_o), 64'd0);
    check("rst_tsize", 64'(bus.user_tsize_o), 64'd0);
    check("rst_len_err", 64'(bus.len_err_o), 64'd0);
    check("rst_timeout", 64'(bus.timeout_o), 64'd0);
    check("rst_req_tready", 64'(bus.req_tready_o), 64'd0);

    log_rst = 1'b0;
    bus.nwr_ready_in   = 1'b1;
    bus.user_tready_in = 1'b1;

    // Engine gating: no grant while busy or not ready.
    bus.req_valid_i = 4'b0001;
    bus.nwr_busy_in = 1'b1;
    step();
    step();
    check("busy_gate", 64'(bus.grant_o), 64'd0);
    bus.nwr_busy_in  = 1'b0;
    bus.nwr_ready_in = 1'b0;
    step();
    check("ready_gate", 64'(bus.grant_o), 64'd0);
    bus.nwr_ready_in = 1'b1;

    for (int i = 0; i < 10; i++) run_pkt(i, vecs[i]);

    // Reset in the middle of a 32-beat packet from source 2.
    bus.req_valid_i = 4'b0100;
    bus.req_tsize_i[2*20 +: 20] = 20'd255;
    step();
    check("mid_grant", 64'(bus.grant_o), 64'h4);
    bus.req_valid_i = '0;
    for (int b = 0; b <= 5; b++) begin
      bus.req_tvalid_i[2] = 1'b1;
      bus.req_tdata_i[2*64 +: 64] = mk_data(2, b);
      if (b == 5) log_rst = 1'b1;
      step();
    end
    check("mid_rst_grant", 64'(bus.grant_o), 64'd0);
    check("mid_rst_tvalid", 64'(bus.user_tvalid_o), 64'd0);
    check("mid_rst_tdata", bus.user_tdata_o, 64'd0);
    check("mid_rst_addr", 64'(bus.user_addr_o), 64'd0);
    check("mid_rst_tsize", 64'(bus.user_tsize_o), 64'd0);
    check("mid_rst_tready", 64'(bus.req_tready_o), 64'd0);
    log_rst = 1'b0;
    bus.req_tvalid_i[2] = 1'b0;

    // After reset, source 0 must win over source 3.
    rv = '{4'b1001, 0, 20'd7, 1, 1, -1, 1'b0};
    run_pkt(10, rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
